// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity convention (common with
// the TX parity calculator), legal oversample ratios and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Expected parity bit from the XOR-reduction of the data word.
    function automatic logic parity_bit(input logic data_xor, input logic ptype);
        return (ptype == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// UART receive-side bus bundle.
//   master: drives the serial line and frame configuration, observes results.
//   slave : the receiver; consumes line/config, produces word and strobes.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      parity_enable;
    logic                      parity_type;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      parity_error;
    logic                      stop_error;

    modport master (
        output RX_IN, Prescale, parity_enable, parity_type,
        input  P_DATA, Data_Valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, Prescale, parity_enable, parity_type,
        output P_DATA, Data_Valid, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Three-point majority sampler for one UART bit period.
//   CLK, RST       : clock, synchronous active-high reset
//   edge_cnt       : position inside the current bit (0..prescale-1)
//   prescale       : captured oversample ratio
//   rx_in          : serial line
//   bit_c          : 2-of-3 majority, meaningful while sample_done_c is high
//   sample_done_c  : high in the cycle of the third sample
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      rx_in,
    output logic                      bit_c,
    output logic                      sample_done_c
);
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      s_first;
    logic                      s_second;

    assign half = prescale >> 1;

    // First two samples are held; the third is taken live so the FSM can
    // act on the majority in the same cycle and register its result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_first  <= 1'b1;
            s_second <= 1'b1;
        end else begin
            if (edge_cnt == half - PRESCALE_WIDTH'(1)) s_first  <= rx_in;
            if (edge_cnt == half)                      s_second <= rx_in;
        end
    end

    assign sample_done_c = (edge_cnt == half + PRESCALE_WIDTH'(1));
    assign bit_c = (s_first & s_second) | (s_first & rx_in) | (s_second & rx_in);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start detection, LSB-first deserialization, optional parity
// check and stop-bit check, with registered word and one-cycle strobes.
//   CLK, RST : oversampling clock, synchronous active-high reset
//   bus      : slave side of uart_rx_frame_if (RX_IN, Prescale, parity_enable,
//              parity_type in; P_DATA, Data_Valid, parity_error, stop_error out)
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_frame_if.slave bus
);
    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_type_q;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      par_err;

    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      parity_error;
    logic                      stop_error;

    logic                      bit_c;
    logic                      sample_done_c;
    logic                      bit_end_c;

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .edge_cnt      (edge_cnt),
        .prescale      (prescale_q),
        .rx_in         (bus.RX_IN),
        .bit_c         (bit_c),
        .sample_done_c (sample_done_c)
    );

    assign bit_end_c = (edge_cnt == prescale_q - PRESCALE_WIDTH'(1));

    // Frame FSM with counters, shift register, checks and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            prescale_q   <= PRESCALE_WIDTH'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_type_q   <= PARITY_EVEN;
            shreg        <= '0;
            par_err      <= 1'b0;
            p_data       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= bit_end_c ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    // The detection cycle is edge 0 of the start bit.
                    if (!bus.RX_IN) begin
                        state      <= START;
                        edge_cnt   <= PRESCALE_WIDTH'(1);
                        bit_cnt    <= '0;
                        prescale_q <= bus.Prescale;
                        par_en_q   <= bus.parity_enable;
                        par_type_q <= bus.parity_type;
                        par_err    <= 1'b0;
                    end
                end
                START: begin
                    if (sample_done_c && bit_c) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (bit_end_c) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample_done_c) begin
                        shreg <= {bit_c, shreg[DATA_WIDTH-1:1]};
                    end
                    if (bit_end_c) begin
                        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sample_done_c) begin
                        par_err <= (bit_c != parity_bit(^shreg, par_type_q));
                    end
                    if (bit_end_c) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Leave early so a back-to-back start bit is not missed.
                    if (sample_done_c) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        if (bit_c && !par_err) begin
                            data_valid <= 1'b1;
                            p_data     <= shreg;
                        end else begin
                            stop_error   <= ~bit_c;
                            parity_error <= par_err;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.P_DATA       = p_data;
    assign bus.Data_Valid   = data_valid;
    assign bus.parity_error = parity_error;
    assign bus.stop_error   = stop_error;

endmodule
